ksa_param: RTL and testbench

Parametrised ARC4 key-scheduling engine, successor to the fixed 24-bit `ksa`. It supports a configurable key length and an optional built-in S-box initialisation pass, so the top level no longer needs a separate `init` block. It drives a single-port 256×8 S-memory (synchronous write, 1-cycle read latency) and uses the same `en`/`rdy` handshake as the other ARC4 datapath blocks.

---
 rtl/ksa_param.sv | 144 ++++++++++++++
 tb/tb_ksa_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_param.sv
// ARC4 key-scheduling engine with configurable key length and an optional
// built-in identity initialisation of the S-memory before the swap loop.
module ksa_param #(
  parameter int KEY_BYTES = 3,
  parameter int INIT_EN   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, INIT, RDI, CAPI, RDJ, CAPJ, WRI, WRJ} state_t;

  state_t                 state, state_n;
  logic [7:0]             i, i_n, j, j_n;
  logic [KW-1:0]          kidx, kidx_n;
  logic [7:0]             addr_n, wrdata_n;
  logic                   wren_n, rdy_n;
  logic [7:0]             si, si_n;
  logic [8*KEY_BYTES-1:0] key_q;
  logic                   key_ld;
  logic [7:0]             kb;

  // Key byte selected by the wrapping key index; byte 0 sits in the MSBs.
  always_comb begin
    kb = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx == KW'(k)) kb = key_q[8*(KEY_BYTES-1-k) +: 8];
    end
  end

  // Outputs are registered from the next state, so each state's memory
  // access is already on the bus during the cycle the state is occupied.
  always_comb begin
    state_n  = state;
    i_n      = i;
    j_n      = j;
    kidx_n   = kidx;
    si_n     = si;
    addr_n   = addr;
    wrdata_n = wrdata;
    wren_n   = 1'b0;
    rdy_n    = rdy;
    key_ld   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          key_ld = 1'b1;
          i_n    = 8'd0;
          j_n    = 8'd0;
          kidx_n = '0;
          rdy_n  = 1'b0;
          addr_n = 8'd0;
          if (INIT_EN != 0) begin
            state_n  = INIT;
            wrdata_n = 8'd0;
            wren_n   = 1'b1;
          end else begin
            state_n = RDI;
          end
        end
      end
      INIT: begin
        i_n    = i + 8'd1;
        addr_n = i + 8'd1;
        if (i == 8'hFF) begin
          state_n = RDI;
        end else begin
          wrdata_n = i + 8'd1;
          wren_n   = 1'b1;
        end
      end
      RDI: state_n = CAPI;
      CAPI: begin
        si_n    = rddata;
        j_n     = j + rddata + kb;
        addr_n  = j + rddata + kb;
        state_n = RDJ;
      end
      RDJ: state_n = CAPJ;
      CAPJ: begin
        // wrdata doubles as the S[j] holding register for the WRI write
        addr_n   = i;
        wrdata_n = rddata;
        wren_n   = 1'b1;
        state_n  = WRI;
      end
      WRI: begin
        addr_n   = j;
        wrdata_n = si;
        wren_n   = 1'b1;
        state_n  = WRJ;
      end
      WRJ: begin
        i_n    = i + 8'd1;
        kidx_n = (kidx == KW'(KEY_BYTES-1)) ? '0 : kidx + KW'(1);
        if (i == 8'hFF) begin
          state_n = IDLE;
          rdy_n   = 1'b1;
        end else begin
          addr_n  = i + 8'd1;
          state_n = RDI;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      i      <= 8'd0;
      j      <= 8'd0;
      kidx   <= '0;
      addr   <= 8'd0;
      wrdata <= 8'd0;
      wren   <= 1'b0;
      rdy    <= 1'b1;
    end else begin
      state  <= state_n;
      i      <= i_n;
      j      <= j_n;
      kidx   <= kidx_n;
      addr   <= addr_n;
      wrdata <= wrdata_n;
      wren   <= wren_n;
      rdy    <= rdy_n;
    end
  end

  always_ff @(posedge clk) begin
    si <= si_n;
    if (key_ld) key_q <= key;
  end

endmodule

// File: tb/tb_ksa_param.sv
// Bench for ksa_param: four instances with different key lengths and init
// modes, each attached to a 1-cycle-latency behavioural S-memory.
`timescale 1ns/1ps
module tb_ksa_param;

  localparam int N = 4;

  function automatic int kb_of(input int g);
    case (g)
      0: return 3;
      1: return 3;
      2: return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int ie_of(input int g);
    return (g == 0 || g == 2) ? 1 : 0;
  endfunction

  logic         clk = 1'b0;
  logic         rst;
  logic         en_v    [N];
  logic         rdy_v   [N];
  logic [255:0] key_bus [N];
  logic [7:0]   addr_v  [N];
  logic [7:0]   rddata_v[N];
  logic [7:0]   wrdata_v[N];
  logic         wren_v  [N];
  logic         pre_v   [N];

  logic [7:0] mem [N][256];
  logic [7:0] wa  [N][4096];
  logic [7:0] wd  [N][4096];
  int         logn[N] = '{default: 0};

  logic [7:0] ms[256];
  logic [7:0] mj[256];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int KB = kb_of(g);
    ksa_param #(.KEY_BYTES(KB), .INIT_EN(ie_of(g))) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en_v[g]),
      .rdy    (rdy_v[g]),
      .key    (key_bus[g][8*KB-1:0]),
      .addr   (addr_v[g]),
      .rddata (rddata_v[g]),
      .wrdata (wrdata_v[g]),
      .wren   (wren_v[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (pre_v[g]) begin
        for (int k = 0; k < 256; k++) mem[g][k] <= 8'(k);
      end else if (wren_v[g]) begin
        mem[g][addr_v[g]]    <= wrdata_v[g];
        wa[g][logn[g]%4096]  <= addr_v[g];
        wd[g][logn[g]%4096]  <= wrdata_v[g];
        logn[g]              <= logn[g] + 1;
      end
      rddata_v[g] <= mem[g][addr_v[g]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference KSA on ms[]; mj[i] records j after step i.
  function automatic void ksa_model(input logic [255:0] k, input int kbytes, input bit do_init);
    logic [7:0] j, t, kbv;
    int ki;
    if (do_init) for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      ki     = i % kbytes;
      kbv    = k[8*(kbytes-1-ki) +: 8];
      j      = j + ms[i] + kbv;
      mj[i]  = j;
      t      = ms[i];
      ms[i]  = ms[j];
      ms[j]  = t;
    end
  endfunction

  function automatic int count_mis(input int g);
    int n = 0;
    for (int k = 0; k < 256; k++) if (mem[g][k] !== ms[k]) n++;
    return n;
  endfunction

  task automatic start_run(input int g, input logic [255:0] k);
    key_bus[g] = k;
    en_v[g]    = 1'b1;
    @(negedge clk);
    en_v[g]    = 1'b0;
  endtask

  task automatic wait_done(input int g, output int n);
    n = 0;
    while (rdy_v[g] !== 1'b1 && n < 4000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic preload(input int g);
    pre_v[g] = 1'b1;
    @(negedge clk);
    pre_v[g] = 1'b0;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, base, act, mis, lsum;
    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      en_v[g] = 1'b0; key_bus[g] = '0; pre_v[g] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check_eq($sformatf("rst_rdy%0d", g),  rdy_v[g],  1);
      check_eq($sformatf("rst_wren%0d", g), wren_v[g], 0);
      check_eq($sformatf("rst_addr%0d", g), addr_v[g], 0);
    end
    act = 0;
    lsum = logn[0] + logn[1] + logn[2] + logn[3];
    repeat (20) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) if (wren_v[g] !== 1'b0) act++;
    end
    check_eq("idle_wren", act, 0);
    check_eq("idle_writes", logn[0] + logn[1] + logn[2] + logn[3], lsum);

    // KEY_BYTES=3 with built-in init
    base = logn[0];
    start_run(0, 256'h035F3C);
    wait_done(0, n);
    check_eq("a_busy", n, 1792);
    check_eq("a_nwrites", logn[0] - base, 768);
    mis = 0;
    for (int k = 0; k < 256; k++)
      if (wa[0][(base+k)%4096] !== 8'(k) || wd[0][(base+k)%4096] !== 8'(k)) mis++;
    check_eq("a_init_writes", mis, 0);
    check_eq("a_w0_addr", wa[0][(base+256)%4096], 8'h00);
    check_eq("a_w0_data", wd[0][(base+256)%4096], 8'h03);
    check_eq("a_w1_addr", wa[0][(base+257)%4096], 8'h03);
    check_eq("a_w1_data", wd[0][(base+257)%4096], 8'h00);
    check_eq("a_w2_addr", wa[0][(base+258)%4096], 8'h01);
    check_eq("a_w2_data", wd[0][(base+258)%4096], 8'h63);
    check_eq("a_w3_addr", wa[0][(base+259)%4096], 8'h63);
    check_eq("a_w3_data", wd[0][(base+259)%4096], 8'h01);
    ksa_model(256'h035F3C, 3, 1);
    check_eq("a_final_s", count_mis(0), 0);

    // KEY_BYTES=3, preloaded memory, all-zero key
    preload(1);
    base = logn[1];
    start_run(1, 256'h0);
    wait_done(1, n);
    check_eq("b_busy", n, 1536);
    check_eq("b_w0_addr", wa[1][base%4096],     8'h00);
    check_eq("b_w0_data", wd[1][base%4096],     8'h00);
    check_eq("b_w1_addr", wa[1][(base+1)%4096], 8'h00);
    check_eq("b_w1_data", wd[1][(base+1)%4096], 8'h00);
    ksa_model(256'h0, 3, 0);
    check_eq("b_final_s", count_mis(1), 0);

    // KEY_BYTES=16 with built-in init
    base = logn[2];
    start_run(2, 256'h9E3779B97F4A7C15F39CC0605CEDC834);
    wait_done(2, n);
    check_eq("c_busy", n, 1792);
    ksa_model(256'h9E3779B97F4A7C15F39CC0605CEDC834, 16, 1);
    check_eq("c_j_i15", wa[2][(base+256+31)%4096], mj[15]);
    check_eq("c_j_i16", wa[2][(base+256+33)%4096], mj[16]);
    check_eq("c_final_s", count_mis(2), 0);

    // KEY_BYTES=1, preloaded memory: j = A7 then A7+1+A7
    preload(3);
    base = logn[3];
    start_run(3, 256'hA7);
    wait_done(3, n);
    check_eq("d_busy", n, 1536);
    check_eq("d_j_i0", wa[3][(base+1)%4096], 8'hA7);
    check_eq("d_j_i1", wa[3][(base+3)%4096], 8'h4F);
    ksa_model(256'hA7, 1, 0);
    check_eq("d_final_s", count_mis(3), 0);

    // Handshake: en pulses and key churn while busy, then back-to-back start
    preload(1);
    start_run(1, 256'h1A2B3C);
    n = 0;
    while (rdy_v[1] !== 1'b1 && n < 4000) begin
      n++;
      if (n >= 1530) begin
        en_v[1] = 1'b1;
        key_bus[1] = 256'hC0FFEE;
      end else begin
        en_v[1] = (n % 97 == 3);
        key_bus[1] = 256'($urandom);
      end
      @(negedge clk);
    end
    check_eq("hs_busy1", n, 1536);
    ksa_model(256'h1A2B3C, 3, 0);
    check_eq("hs_final1", count_mis(1), 0);
    @(negedge clk);
    en_v[1] = 1'b0;
    check_eq("hs_b2b_rdy", rdy_v[1], 0);
    wait_done(1, n2);
    check_eq("hs_busy2", n2, 1536);
    ksa_model(256'hC0FFEE, 3, 0);
    check_eq("hs_final2", count_mis(1), 0);

    // Asynchronous reset in the middle of a run
    start_run(0, 256'h035F3C);
    repeat (699) @(negedge clk);
    n = 0;
    while (wren_v[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("rr_wren_active", wren_v[0], 1);
    #1 rst = 1'b1;
    #1;
    check_eq("rr_wren", wren_v[0], 0);
    check_eq("rr_rdy", rdy_v[0], 1);
    check_eq("rr_addr", addr_v[0], 0);
    check_eq("rr_wrdata", wrdata_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rr_rdy_after", rdy_v[0], 1);
    start_run(0, 256'h035F3C);
    wait_done(0, n);
    check_eq("rr_busy", n, 1792);
    ksa_model(256'h035F3C, 3, 1);
    check_eq("rr_final_s", count_mis(0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
